pokey_chan_out: RTL

//  Audio channel output stage. Sits directly downstream of the channel's AUDF down-counter cell chain.

---
 rtl/pokey_chan_out.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pokey_chan_out.sv
// -----------------------------------------------------------------------------
// pokey_chan_out
//
// Audio channel output stage. Sits directly downstream of the channel's AUDF
// down-counter chain: it watches the chain's active-low borrow, fires a
// one-tick reload strobe back into the chain, holds the AUDC control register
// and turns the channel's tone flop into a 4-bit audio level through
// distortion gating, an optional high-pass flop and the volume field.
//
// All state advances on the falling edge of clk, and only on ticks where
// enn=1. Reset is asynchronous and active low.
//
// Build option:
//   POKEY_HPF_EN  When defined, the high-pass flop is implemented: on an enn
//                 tick with hpf_sel=1 and hpf_clk=1 it samples the tone flop,
//                 and it is cleared whenever hpf_sel=0. When undefined, the
//                 high-pass flop is constant 0 and hpf_sel/hpf_clk are
//                 ignored.
//
// Parameters:
//   VOLW     width of the volume field and audio output (default 4)
//
// Ports:
//   clk      master clock, state updates on its falling edge
//   nRST     asynchronous active-low reset
//   enn      clock-phase enable
//   WR       AUDC write strobe
//   D[7:0]   data bus: [7:5] distortion, [4] volume-only, [3:0] volume
//   nBOR     borrow from the counter chain MSB cell, active low
//   poly4    4-bit poly counter output
//   poly5    5-bit poly counter output
//   poly17   17-bit poly counter output
//   hpf_sel  high-pass enable
//   hpf_clk  borrow from the paired channel, active high
//   Ld       reload strobe to the counter chain, active high
//   vol      channel audio level
// -----------------------------------------------------------------------------
module pokey_chan_out #(
    parameter int VOLW = 4
) (
    input  logic            clk,
    input  logic            nRST,
    input  logic            enn,
    input  logic            WR,
    input  logic [7:0]      D,
    input  logic            nBOR,
    input  logic            poly4,
    input  logic            poly5,
    input  logic            poly17,
    input  logic            hpf_sel,
    input  logic            hpf_clk,
    output logic            Ld,
    output logic [VOLW-1:0] vol
);

    // AUDC field positions
    localparam int DIST_POLY5 = 7;  // 0: gate tone updates with poly5
    localparam int DIST_SEL4  = 6;  // 1: poly4 noise, 0: poly17 noise
    localparam int DIST_PURE  = 5;  // 1: pure square tone
    localparam int VOL_ONLY   = 4;  // 1: output volume directly

    logic [7:0]      audc_reg, audc_next;
    logic            tone_reg, tone_next;
    logic            ld_reg,   ld_next;
    logic [VOLW-1:0] vol_reg,  vol_next;
    logic            hpf_reg;

    logic            underflow;
    logic            gate;
    logic [VOLW-1:0] level;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // While Ld is high the chain is being reloaded and its borrow is not
        // meaningful, so a new pulse is only accepted when Ld is low. A stuck
        // borrow therefore produces an alternating 1,0,1,0 strobe.
        underflow = ~nBOR & ~ld_reg;
        gate      = tone_reg ^ hpf_reg;
        level     = VOLW'(audc_reg[3:0]);

        audc_next = audc_reg;
        if (WR) begin
            audc_next = D;
        end

        ld_next = underflow;

        // Distortion is decoded from the current AUDC, so a write landing on
        // the same tick as an underflow only affects later underflows.
        tone_next = tone_reg;
        if (underflow) begin
            if (!audc_reg[DIST_POLY5] && !poly5) begin
                tone_next = tone_reg;
            end else if (audc_reg[DIST_PURE]) begin
                tone_next = ~tone_reg;
            end else if (audc_reg[DIST_SEL4]) begin
                tone_next = poly4;
            end else begin
                tone_next = poly17;
            end
        end

        vol_next = '0;
        if (audc_reg[VOL_ONLY] || gate) begin
            vol_next = level;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or negedge nRST) begin
        if (!nRST) begin
            audc_reg <= '0;
            tone_reg <= 1'b0;
            ld_reg   <= 1'b0;
            vol_reg  <= '0;
        end else if (enn) begin
            audc_reg <= audc_next;
            tone_reg <= tone_next;
            ld_reg   <= ld_next;
            vol_reg  <= vol_next;
        end
    end

`ifdef POKEY_HPF_EN
    // High-pass flop: samples the tone flop value from before any update on
    // the same tick, and is held clear while the high-pass is disabled.
    logic hpf_next;

    always_comb begin
        hpf_next = hpf_reg;
        if (!hpf_sel) begin
            hpf_next = 1'b0;
        end else if (hpf_clk) begin
            hpf_next = tone_reg;
        end
    end

    always_ff @(negedge clk or negedge nRST) begin
        if (!nRST) begin
            hpf_reg <= 1'b0;
        end else if (enn) begin
            hpf_reg <= hpf_next;
        end
    end
`else
    // High-pass not built: the gate follows the tone flop directly and the
    // high-pass controls are deliberately left unconnected.
    assign hpf_reg = 1'b0;

    logic hpf_unused;
    assign hpf_unused = &{1'b0, hpf_sel, hpf_clk};
`endif

    assign Ld  = ld_reg;
    assign vol = vol_reg;

endmodule
